approx_sweep_ctrl: RTL and testbench



---
 rtl/approx_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_approx_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_sweep_ctrl.sv
// approx_sweep_ctrl: exhaustive-sweep controller for approximate-circuit evaluation.
// Walks every N_IN-bit input vector, holds each one for SETTLE cycles so both
// combinational circuits can settle, then samples their outputs. It tracks
// the worst-case absolute error and the number of vectors whose error exceeds ET.
//
// Optional build macro: APPROX_SWEEP_EARLY_ABORT_EN
//   defined   : the first violating vector ends the sweep. vec keeps that vector.
//   undefined : every sweep covers all 2^N_IN vectors.
module approx_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int ET     = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic [N_OUT-1:0]  exact_in,
  input  logic [N_OUT-1:0]  approx_in,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  max_err,
  output logic [N_IN:0]     err_count,
  output logic              pass
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Settle counter only needs to reach SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  // Threshold widened by one bit so any ET that fits N_OUT+1 bits compares cleanly.
  localparam logic [N_OUT:0] ET_V = ET[N_OUT:0];

  // err_count saturates at the total number of vectors, 2^N_IN.
  localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

`ifdef APPROX_SWEEP_EARLY_ABORT_EN
  localparam logic ABORT_ON_VIOL = 1'b1;
`else
  localparam logic ABORT_ON_VIOL = 1'b0;
`endif

  // Unsigned absolute difference. The result always fits in N_OUT bits
  // because the smaller operand is subtracted from the larger one.
  function automatic logic [N_OUT-1:0] abs_diff(input logic [N_OUT-1:0] a,
                                                input logic [N_OUT-1:0] b);
    if (a >= b) return a - b;
    else        return b - a;
  endfunction

  // Larger of two unsigned error values.
  function automatic logic [N_OUT-1:0] max_of(input logic [N_OUT-1:0] a,
                                              input logic [N_OUT-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Violation counter increment that saturates at CNT_MAX.
  function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    else              return c + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic [N_OUT-1:0] err;
  logic             viol;
  logic             vec_last;

  // Error of the currently driven vector; it is only used while in SAMPLE.
  always_comb begin
    err      = abs_diff(exact_in, approx_in);
    viol     = ({1'b0, err} > ET_V);
    vec_last = (vec == {N_IN{1'b1}});
  end

  // Sweep FSM together with the vector, settle counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      max_err    <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= '0;
            max_err    <= '0;
            err_count  <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          max_err <= max_of(max_err, err);
          if (viol) err_count <= sat_inc(err_count);
          // The terminal vector ends the sweep; vec never wraps back to zero.
          if (vec_last || (ABORT_ON_VIOL && viol)) begin
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded from the state register. pass follows max_err directly.
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
    pass = ({1'b0, max_err} <= ET_V);
  end

endmodule

// File: tb/tb_approx_sweep_ctrl.sv
// Self-checking bench for approx_sweep_ctrl (default parameters).
// A behavioural model fills a scoreboard entry each time a sweep is launched.
// The entry is popped and compared when done rises.
module tb_approx_sweep_ctrl;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int ET     = 3;
  localparam int SETTLE = 1;
  localparam int NV     = 1 << N_IN;

`ifdef APPROX_SWEEP_EARLY_ABORT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N_IN-1:0]   vec;
  logic [N_OUT-1:0]  exact_in;
  logic [N_OUT-1:0]  approx_in;
  logic              busy;
  logic              done;
  logic [N_OUT-1:0]  max_err;
  logic [N_IN:0]     err_count;
  logic              pass;

  int mode;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int max_err;
    int cnt;
    int pass;
    int vec;
    int cycles;
  } exp_t;

  exp_t sb[$];

  approx_sweep_ctrl #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec),
    .exact_in(exact_in), .approx_in(approx_in),
    .busy(busy), .done(done), .max_err(max_err),
    .err_count(err_count), .pass(pass)
  );

  always #5 clk = ~clk;

  // Circuit pairs under evaluation, selected by mode.
  function automatic logic [2:0] f_exact(input int m, input logic [3:0] v);
    case (m)
      0:       return v[2:0] ^ {v[3], v[3], v[3]};
      1:       return v[2:0];
      2:       return 3'd3;
      default: return 3'((v * 5) + 1);
    endcase
  endfunction

  function automatic logic [2:0] f_approx(input int m, input logic [3:0] v);
    case (m)
      0:       return v[2:0] ^ {v[3], v[3], v[3]};
      1:       return 3'd0;
      2:       return 3'd0;
      default: return 3'(v ^ 4'h6);
    endcase
  endfunction

  always_comb begin
    exact_in  = f_exact(mode, vec);
    approx_in = f_approx(mode, vec);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of one sweep for circuit pair m.
  task automatic push_expected(input int m);
    exp_t e;
    int a, b, d;
    e.max_err = 0;
    e.cnt     = 0;
    e.vec     = NV - 1;
    e.cycles  = NV * (SETTLE + 1);
    for (int v = 0; v < NV; v++) begin
      a = int'(f_exact(m, 4'(v)));
      b = int'(f_approx(m, 4'(v)));
      d = (a > b) ? a - b : b - a;
      if (d > e.max_err) e.max_err = d;
      if (d > ET) e.cnt++;
      if (EARLY && d > ET) begin
        e.vec    = v;
        e.cycles = (v + 1) * (SETTLE + 1);
        break;
      end
    end
    e.pass = (e.max_err <= ET) ? 1 : 0;
    sb.push_back(e);
  endtask

  // Launch one sweep, optionally re-pulsing start at a cycle mid-sweep, and check it.
  task automatic run_sweep(input string name, input int m, input int restart_at);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    logic [N_OUT-1:0] hold_max;
    logic [N_IN:0]    hold_cnt;
    mode = m;
    push_expected(m);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ":busy_edge0"}, 32'(busy), 32'd1);
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == restart_at);
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({name, ":done_seen"}, 32'(done), 32'd1);
    check({name, ":cycles"}, 32'(cyc), 32'(e.cycles));
    check({name, ":busy_during"}, 32'(busy_ok), 32'd1);
    check({name, ":busy_at_done"}, 32'(busy), 32'd0);
    check({name, ":max_err"}, 32'(max_err), 32'(e.max_err));
    check({name, ":err_count"}, 32'(err_count), 32'(e.cnt));
    check({name, ":pass"}, 32'(pass), 32'(e.pass));
    check({name, ":vec"}, 32'(vec), 32'(e.vec));
    hold_max = max_err;
    hold_cnt = err_count;
    @(posedge clk);
    #1;
    check({name, ":done_one_cycle"}, 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, ":max_err_hold"}, 32'(max_err), 32'(e.max_err));
    check({name, ":err_count_hold"}, 32'(err_count), 32'(e.cnt));
    check({name, ":pass_hold"}, 32'(pass), 32'(e.pass));
    check({name, ":idle_busy"}, 32'(busy), 32'd0);
    if (hold_max !== max_err || hold_cnt !== err_count) begin
      check({name, ":hold_stable"}, 32'(max_err), 32'(hold_max));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:vec", 32'(vec), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:max_err", 32'(max_err), 32'd0);
    check("reset:err_count", 32'(err_count), 32'd0);
    check("reset:pass", 32'(pass), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Identical circuits: no error at all, full-length sweep.
    run_sweep("equal", 0, -1);
    // exact = vec[2:0], approx = 0: errors 0..7, half of them violate.
    run_sweep("ramp", 1, -1);
    // Constant error exactly at the threshold is not a violation.
    run_sweep("at_et", 2, -1);
    // Mixed error pattern.
    run_sweep("mixed", 3, -1);
    // Extra start pulse in the middle of a sweep is ignored.
    run_sweep("restart", 1, 5);

    // Asynchronous reset in the middle of a sweep.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort:busy_before", 32'(busy), 32'd1);
    check("abort:max_err_before", 32'(max_err), 32'd3);
    rst = 1'b1;
    #1;
    check("abort:vec", 32'(vec), 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:max_err", 32'(max_err), 32'd0);
    check("abort:err_count", 32'(err_count), 32'd0);
    check("abort:pass", 32'(pass), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      check("abort:no_done", 32'(done), 32'd0);
    end
    run_sweep("after_abort", 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
